// File: rtl/count_sched.sv
// count_sched: round-robin scheduler that grants one of four requesters a
// counting run of (Len+1) cycles, then signals completion with a one-cycle pulse.
//
// Ports:
//   i_Clk   - clock, all state changes on the rising edge
//   i_Rst   - synchronous active-high reset
//   i_Req   - per-requester request level, bit n = requester n
//   i_Len   - per-requester 3-bit run length, i_Len[3n+2:3n] for requester n
//   o_Gnt   - one-hot grant, held for the whole run of the owner
//   o_Cout  - shared count value, 0..Len during a run, 0 otherwise
//   o_Busy  - high while a run is active or completing
//   o_Done  - one-cycle one-hot completion pulse to the owner
module count_sched (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [3:0]  i_Req,
    input  logic [11:0] i_Len,
    output logic [3:0]  o_Gnt,
    output logic [2:0]  o_Cout,
    output logic        o_Busy,
    output logic [3:0]  o_Done
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned PTR_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   gnt_d, done_d;
    logic               busy_d;

    logic [CNT_W-1:0]   len_fld [N_REQ];
    logic [PTR_W-1:0]   win, idx;
    logic               win_vld;
    logic               own_req;
    logic               at_len;

    // Split the packed length bus into one field per requester.
    always_comb begin
        for (int n = 0; n < N_REQ; n++) begin
            len_fld[n] = i_Len[n*CNT_W +: CNT_W];
        end
    end

    // Round-robin search starting just after the last completed winner.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = PTR_W'(ptr_q + PTR_W'(i));
            if (!win_vld && i_Req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign own_req = i_Req[owner_q];
    assign at_len  = (cnt_q == len_q);

    // State register plus registered outputs and datapath.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state   <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= PTR_W'(N_REQ - 1);
            owner_q <= '0;
            o_Gnt   <= '0;
            o_Busy  <= 1'b0;
            o_Done  <= '0;
        end else begin
            state   <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            o_Gnt   <= gnt_d;
            o_Busy  <= busy_d;
            o_Done  <= done_d;
        end
    end

    // Count is held at zero outside RUN, so it is the count output directly.
    assign o_Cout = cnt_q;

    // Next-state logic; a dropped owner request beats reaching the length.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (win_vld) state_d = S_RUN;
            S_RUN: begin
                if (!own_req)    state_d = S_IDLE;
                else if (at_len) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        gnt_d   = '0;
        done_d  = '0;
        cnt_d   = '0;
        len_d   = len_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_d   = N_REQ'(1) << win;
                    owner_d = win;
                    len_d   = len_fld[win];
                end
            end
            S_RUN: begin
                if (own_req && !at_len) begin
                    gnt_d = o_Gnt;
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (own_req) begin
                    // Pointer moves only on a completed run.
                    done_d = o_Gnt;
                    ptr_d  = owner_q;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_count_sched.sv
// Testbench for count_sched: directed scenarios and a randomized run, all
// checked through an expected-output queue filled as stimulus is applied.
module tb_count_sched;

    logic        i_Clk;
    logic        i_Rst;
    logic [3:0]  i_Req;
    logic [11:0] i_Len;
    logic [3:0]  o_Gnt;
    logic [2:0]  o_Cout;
    logic        o_Busy;
    logic [3:0]  o_Done;

    logic [11:0] obs;
    logic [11:0] expv;
    logic [11:0] sb_q [$];
    int          n_vec;
    int          n_err;

    // Reference model state for the random scenario.
    int m_st, m_own, m_len, m_cnt, m_ptr, exp_run, run_cnt;

    count_sched dut (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Req  (i_Req),
        .i_Len  (i_Len),
        .o_Gnt  (o_Gnt),
        .o_Cout (o_Cout),
        .o_Busy (o_Busy),
        .o_Done (o_Done)
    );

    assign obs = {o_Gnt, o_Cout, o_Busy, o_Done};

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    function automatic logic [11:0] ev(int g, int c, int b, int d);
        return {4'(g), 3'(c), 1'(b), 4'(d)};
    endfunction

    task automatic apply_reset();
        i_Rst = 1'b1; i_Req = '0; i_Len = '0;
        @(posedge i_Clk); #1;
        i_Rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        i_Rst = 1'b1; i_Req = 4'hF; i_Len = 12'hFFF;
        repeat (3) sb_q.push_back(ev(0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(posedge i_Clk); #1;
            expv = (sb_q.size() != 0) ? sb_q.pop_front() : 12'hxxx;
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL reset k=%0d got gnt_cout_busy_done=%b want %b", k, obs, expv);
            end
        end
        i_Rst = 1'b0; i_Req = '0; i_Len = '0;
    endtask

    task automatic test_single();
        i_Req = 4'b0001; i_Len = 12'h002;
        sb_q.push_back(ev(1, 0, 1, 0));
        sb_q.push_back(ev(1, 1, 1, 0));
        sb_q.push_back(ev(1, 2, 1, 0));
        sb_q.push_back(ev(0, 0, 1, 1));
        sb_q.push_back(ev(0, 0, 0, 0));
        sb_q.push_back(ev(0, 0, 0, 0));
        for (int k = 0; k < 6; k++) begin
            @(posedge i_Clk); #1;
            expv = (sb_q.size() != 0) ? sb_q.pop_front() : 12'hxxx;
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL single k=%0d got gnt_cout_busy_done=%b want %b", k, obs, expv);
            end
            if (k == 3) i_Req = '0;
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        i_Req = 4'hF; i_Len = 12'h000;
        for (int g = 0; g < 4; g++) begin
            sb_q.push_back(ev(1 << g, 0, 1, 0));
            sb_q.push_back(ev(0, 0, 1, 1 << g));
            sb_q.push_back(ev(0, 0, 0, 0));
        end
        sb_q.push_back(ev(1, 0, 1, 0));   // wraps back to requester 0
        sb_q.push_back(ev(0, 0, 0, 0));   // aborted despite count == Len
        sb_q.push_back(ev(0, 0, 0, 0));
        sb_q.push_back(ev(1, 0, 1, 0));   // pointer untouched by the abort
        sb_q.push_back(ev(0, 0, 0, 0));
        for (int k = 0; k < 17; k++) begin
            @(posedge i_Clk); #1;
            expv = (sb_q.size() != 0) ? sb_q.pop_front() : 12'hxxx;
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL round_robin k=%0d got gnt_cout_busy_done=%b want %b", k, obs, expv);
            end
            if (k == 12) i_Req = '0;
            if (k == 14) i_Req = 4'b0011;
            if (k == 15) i_Req = '0;
        end
    endtask

    task automatic test_len_change();
        i_Req = 4'b0100; i_Len = 12'h1C0;
        for (int c = 0; c < 8; c++) sb_q.push_back(ev(4, c, 1, 0));
        sb_q.push_back(ev(0, 0, 1, 4));
        sb_q.push_back(ev(0, 0, 0, 0));
        for (int k = 0; k < 10; k++) begin
            @(posedge i_Clk); #1;
            expv = (sb_q.size() != 0) ? sb_q.pop_front() : 12'hxxx;
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL len_change k=%0d got gnt_cout_busy_done=%b want %b", k, obs, expv);
            end
            if (k == 0) i_Len = 12'h040;
            if (k == 3) i_Len = 12'h000;
            if (k == 8) i_Req = '0;
        end
    endtask

    task automatic test_abort();
        i_Req = 4'b0010; i_Len = 12'h028;
        for (int c = 0; c < 4; c++) sb_q.push_back(ev(2, c, 1, 0));
        sb_q.push_back(ev(0, 0, 0, 0));
        sb_q.push_back(ev(1, 0, 1, 0));
        sb_q.push_back(ev(0, 0, 1, 1));
        sb_q.push_back(ev(0, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            @(posedge i_Clk); #1;
            expv = (sb_q.size() != 0) ? sb_q.pop_front() : 12'hxxx;
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL abort k=%0d got gnt_cout_busy_done=%b want %b", k, obs, expv);
            end
            if (k == 3) i_Req = '0;
            if (k == 4) i_Req = 4'b0011;
            if (k == 6) i_Req = '0;
        end
    endtask

    task automatic test_reset_mid_run();
        i_Req = 4'b0001; i_Len = 12'h007;
        for (int c = 0; c < 5; c++) sb_q.push_back(ev(1, c, 1, 0));
        sb_q.push_back(ev(0, 0, 0, 0));
        sb_q.push_back(ev(2, 0, 1, 0));
        sb_q.push_back(ev(0, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            @(posedge i_Clk); #1;
            expv = (sb_q.size() != 0) ? sb_q.pop_front() : 12'hxxx;
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL reset_mid_run k=%0d got gnt_cout_busy_done=%b want %b", k, obs, expv);
            end
            if (k == 4) i_Rst = 1'b1;
            if (k == 5) begin i_Rst = 1'b0; i_Req = 4'b1010; i_Len = '0; end
            if (k == 6) i_Req = '0;
        end
    endtask

    // Spec-level model: one step per rising edge, returns expected outputs.
    function automatic logic [11:0] model_step(logic [3:0] r, logic [11:0] l);
        logic [11:0] e;
        int w;
        bit found;
        e = ev(0, 0, 0, 0);
        if (m_st == 0) begin
            found = 0; w = 0;
            for (int i = 1; i <= 4; i++) begin
                if (!found && r[(m_ptr + i) % 4]) begin
                    w = (m_ptr + i) % 4; found = 1;
                end
            end
            if (found) begin
                m_st = 1; m_own = w; m_cnt = 0; m_len = int'((l >> (3 * w)) & 12'h7);
                e = ev(1 << w, 0, 1, 0);
            end
        end else if (m_st == 1) begin
            if (!r[m_own]) begin
                m_st = 0;
            end else if (m_cnt == m_len) begin
                m_st = 2; m_ptr = m_own; exp_run = m_len + 1;
                e = ev(0, 0, 1, 1 << m_own);
            end else begin
                m_cnt++;
                e = ev(1 << m_own, m_cnt, 1, 0);
            end
        end else begin
            m_st = 0;
        end
        return e;
    endfunction

    task automatic test_random();
        logic [3:0] last_done;
        apply_reset();
        m_st = 0; m_own = 0; m_len = 0; m_cnt = 0; m_ptr = 3; exp_run = 0; run_cnt = 0;
        last_done = '0;
        for (int k = 0; k < 10000; k++) begin
            for (int b = 0; b < 4; b++) begin
                if (last_done[b])                                 i_Req[b] = 1'b0;
                else if (!i_Req[b] && $urandom_range(0, 3) == 0)  i_Req[b] = 1'b1;
                else if (i_Req[b] && $urandom_range(0, 63) == 0)  i_Req[b] = 1'b0;
            end
            i_Len = 12'($urandom);
            sb_q.push_back(model_step(i_Req, i_Len));
            @(posedge i_Clk); #1;
            expv = (sb_q.size() != 0) ? sb_q.pop_front() : 12'hxxx;
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL random k=%0d got gnt_cout_busy_done=%b want %b", k, obs, expv);
            end
            n_vec++;
            if ($countones(o_Gnt) > 1 || $countones(o_Done) > 1 || (|o_Gnt && |o_Done)) begin
                n_err++;
                $display("FAIL onehot k=%0d got gnt=%b done=%b want one-hot-or-zero, exclusive", k, o_Gnt, o_Done);
            end
            if (|o_Gnt) run_cnt++;
            if (|o_Done) begin
                n_vec++;
                if (run_cnt != exp_run) begin
                    n_err++;
                    $display("FAIL run_length k=%0d got %0d run cycles want %0d", k, run_cnt, exp_run);
                end
            end
            if (o_Gnt == 4'b0) run_cnt = 0;
            last_done = o_Done;
        end
        i_Req = '0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        i_Rst = 1'b1; i_Req = '0; i_Len = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_len_change();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 i_Clk  input  1  single clock; all state updates on rising edge.
REQ-002 i_Rst  input  1  reset, synchronous, active-high.
REQ-003 i_Req  input  4  per-requester request, bit n = requester n; level, held until o_Done[n].
REQ-004 i_Len  input  12  per-requester run length, i_Len[3n+2:3n] for requester n; 3-bit unsigned.
REQ-005 o_Gnt  output  4  one-hot grant; bit n high for the whole run owned by requester n.
REQ-006 o_Cout  output  3  shared 3-bit count value driven during a run.
REQ-007 o_Busy  output  1  high in RUN and DONE states.
REQ-008 o_Done  output  4  one-cycle completion pulse, one-hot, to the owning requester.

Function
REQ-009 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-010 IDLE: i_Req == 0 -> stay IDLE; o_Gnt=0, o_Cout=0, o_Busy=0, o_Done=0.
REQ-011 IDLE with i_Req != 0 -> winner chosen round-robin, next state RUN, o_Gnt=onehot(winner), count=0, Len latched from winner's i_Len field in that same IDLE cycle.
REQ-012 Round-robin: 2-bit pointer holds last winner; search order pointer+1, +2, +3, +4 (mod 4); first asserted i_Req bit wins.
REQ-013 Pointer SHALL update to the winner only on entry to DONE; aborted runs leave pointer unchanged.
REQ-014 RUN: o_Cout = internal count; count increments by 1 each cycle while count != latched Len.
REQ-015 RUN with count == latched Len -> next state DONE; a run therefore lasts Len+1 cycles, o_Cout showing 0..Len.
REQ-016 Len=0 -> one RUN cycle with o_Cout=0; Len=7 -> eight RUN cycles 0..7, no wrap-around occurs.
REQ-017 i_Len changes after the grant cycle SHALL have no effect on the current run.
REQ-018 RUN with the owner's i_Req bit low (abort) -> next state IDLE, o_Gnt=0, o_Cout=0, no o_Done pulse; abort takes precedence over count == Len in the same cycle.
REQ-019 DONE: exactly one cycle; o_Done = previous o_Gnt, o_Gnt=0, o_Cout=0, o_Busy=1; next state IDLE unconditionally.
REQ-020 Minimum spacing between consecutive grants: DONE -> IDLE -> RUN, i.e. at least two cycles with o_Gnt=0.
REQ-021 Requests from non-owners during RUN/DONE SHALL be ignored until the next IDLE arbitration.
REQ-022 All outputs SHALL be registered; o_Gnt at most one bit high, o_Done at most one bit high, never simultaneously non-zero.

Reset
REQ-023 i_Rst=1 at a rising edge SHALL force state IDLE, count 0, pointer 3, o_Gnt=0, o_Cout=0, o_Busy=0, o_Done=0, overriding all other inputs.
REQ-024 Reset asserted mid-RUN or in DONE SHALL drop the run with no o_Done pulse; first arbitration after release favours requester 0.

Verification
REQ-025 Reset, then i_Req=0001, Len0=2 -> o_Gnt=0001 for 3 cycles with o_Cout 0,1,2; then o_Done=0001 one cycle; then IDLE.
REQ-026 Reset, i_Req=1111 held, all Len=0 -> grants in order 0001,0010,0100,1000,0001 with one DONE and one IDLE cycle between each.
REQ-027 Req 2 granted with Len=7, i_Len changed to 1 mid-run -> o_Cout runs 0..7, o_Done=0100.
REQ-028 Req 1 granted Len=5, i_Req[1] dropped when o_Cout=3 -> next cycle IDLE, o_Gnt=0, o_Done stays 0, pointer unchanged (next i_Req=0011 grants 0001... per pointer).
REQ-029 i_Rst pulsed while o_Cout=4 -> next cycle all outputs 0; then i_Req=1010 -> o_Gnt=0010.
REQ-030 Random i_Req/i_Len for 10k cycles -> o_Gnt and o_Done always one-hot or zero, never both non-zero, each o_Done preceded by exactly Len+1 RUN cycles.
